// File: rtl/snake_body_queue_if.sv
// Handshake between the movement calculator (master), the body queue (slave)
// and the board-state writer, which observes the set/clear pulses.
interface snake_body_queue_if #(
  parameter int MAX_LEN = 64
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic             step;
  logic             grow;
  logic [4:0]       new_x;
  logic [4:0]       new_y;
  logic             busy;
  logic             done;
  logic             collision;
  logic             set_valid;
  logic [4:0]       set_x;
  logic [4:0]       set_y;
  logic             clear_valid;
  logic [4:0]       clear_x;
  logic [4:0]       clear_y;
  logic [4:0]       head_x;
  logic [4:0]       head_y;
  logic [4:0]       tail_x;
  logic [4:0]       tail_y;
  logic [LEN_W-1:0] length;
  logic             full;

  modport master (
    output step, grow, new_x, new_y,
    input  busy, done, collision,
    input  set_valid, set_x, set_y, clear_valid, clear_x, clear_y,
    input  head_x, head_y, tail_x, tail_y, length, full
  );

  modport slave (
    input  step, grow, new_x, new_y,
    output busy, done, collision,
    output set_valid, set_x, set_y, clear_valid, clear_x, clear_y,
    output head_x, head_y, tail_x, tail_y, length, full
  );
endinterface

// File: rtl/snake_body_queue.sv
// Ring buffer of snake segments: validates a proposed head against walls and the
// body (one segment per cycle), then commits the move or latches a collision.
module snake_body_queue #(
  parameter int MAX_LEN      = 64,
  parameter int GRID_COLUMNS = 18,
  parameter int GRID_ROWS    = 18,
  parameter int START_X      = 9,
  parameter int START_Y      = 9
) (
  input logic               clk,
  input logic               rst_n,
  snake_body_queue_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } coord_t;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, FAIL} state_t;

  localparam ptr_t       LAST_PTR  = ptr_t'(MAX_LEN - 1);
  localparam len_t       MAX_LEN_L = len_t'(MAX_LEN);
  localparam logic [5:0] COLS_L    = 6'(GRID_COLUMNS);
  localparam logic [5:0] ROWS_L    = 6'(GRID_ROWS);
  localparam coord_t     START     = coord_t'{x: 5'(START_X), y: 5'(START_Y)};

  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  state_t state_q, state_d;

  coord_t mem [MAX_LEN];
  ptr_t   head_ptr, tail_ptr, scan_ptr;
  len_t   len_q, scan_i;
  coord_t target;
  logic   grow_q;
  logic   full_q;
  coord_t head_q, tail_q, set_q, clear_q;
  logic   busy_q, done_q, collision_q, set_valid_q, clear_valid_q;

  logic   accept, wall_hit, seg_hit, scan_last;
  ptr_t   head_inc, tail_inc;

  assign accept    = (state_q == IDLE) && bus.step && !collision_q;
  // A 5-bit 0-1 wraps to 31, which lands outside the grid and counts as a wall.
  assign wall_hit  = ({1'b0, bus.new_x} >= COLS_L) || ({1'b0, bus.new_y} >= ROWS_L);
  // The tail slot is skipped on a plain move: that cell is vacated this step.
  assign seg_hit   = (mem[scan_ptr] == target) && (grow_q || (scan_i != '0));
  assign scan_last = (scan_i == len_q - len_t'(1));
  assign head_inc  = wrap_inc(head_ptr);
  assign tail_inc  = wrap_inc(tail_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = wall_hit ? FAIL : SCAN;
      SCAN: begin
        if (seg_hit)        state_d = FAIL;
        else if (scan_last) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the segment store is a small flop array, so it shares the async reset;
      // only entry 0 carries meaning after reset.
      for (int k = 0; k < MAX_LEN; k++) mem[k] <= '0;
      mem[0]        <= START;
      head_ptr      <= '0;
      tail_ptr      <= '0;
      scan_ptr      <= '0;
      len_q         <= len_t'(1);
      scan_i        <= '0;
      target        <= '0;
      grow_q        <= 1'b0;
      full_q        <= 1'b0;
      head_q        <= START;
      tail_q        <= START;
      set_q         <= '0;
      clear_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      collision_q   <= 1'b0;
      set_valid_q   <= 1'b0;
      clear_valid_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      set_valid_q   <= 1'b0;
      clear_valid_q <= 1'b0;
      busy_q        <= (state_d != IDLE);

      if (accept) begin
        target   <= coord_t'{x: bus.new_x, y: bus.new_y};
        grow_q   <= bus.grow & ~full_q;
        scan_ptr <= tail_ptr;
        scan_i   <= '0;
      end

      if (state_q == SCAN) begin
        scan_ptr <= wrap_inc(scan_ptr);
        scan_i   <= scan_i + len_t'(1);
      end

      if (state_q == COMMIT) begin
        mem[head_inc] <= target;
        head_ptr      <= head_inc;
        head_q        <= target;
        set_q         <= target;
        set_valid_q   <= 1'b1;
        done_q        <= 1'b1;
        if (!grow_q) begin
          clear_valid_q <= 1'b1;
          clear_q       <= tail_q;
          tail_ptr      <= tail_inc;
          // With one segment the new tail is the head being written this cycle.
          tail_q        <= (tail_inc == head_inc) ? target : mem[tail_inc];
        end else begin
          len_q  <= len_q + len_t'(1);
          full_q <= (len_q + len_t'(1) == MAX_LEN_L);
        end
      end

      if (state_q == FAIL) begin
        collision_q <= 1'b1;
        done_q      <= 1'b1;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.collision   = collision_q;
  assign bus.set_valid   = set_valid_q;
  assign bus.set_x       = set_q.x;
  assign bus.set_y       = set_q.y;
  assign bus.clear_valid = clear_valid_q;
  assign bus.clear_x     = clear_q.x;
  assign bus.clear_y     = clear_q.y;
  assign bus.head_x      = head_q.x;
  assign bus.head_y      = head_q.y;
  assign bus.tail_x      = tail_q.x;
  assign bus.tail_y      = tail_q.y;
  assign bus.length      = len_q;
  assign bus.full        = full_q;
endmodule

// File: tb/tb_snake_body_queue.sv
// Bench for snake_body_queue: two instances (MAX_LEN 64 and 4) checked against a
// queue-based model of the snake's body, with directed scenarios and random walks.
module tb_snake_body_queue;
  localparam int LA = 64;
  localparam int LB = 4;

  typedef struct packed {
    logic       busy, done, collision, set_valid, clear_valid, full;
    logic [4:0] set_x, set_y, clear_x, clear_y, head_x, head_y, tail_x, tail_y;
    logic [7:0] length;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b, step_a, step_b, grow;
  logic [4:0] new_x, new_y;
  bit         sel;

  always #5 clk = ~clk;

  snake_body_queue_if #(.MAX_LEN(LA)) ifa ();
  snake_body_queue_if #(.MAX_LEN(LB)) ifb ();

  assign ifa.step  = step_a;
  assign ifa.grow  = grow;
  assign ifa.new_x = new_x;
  assign ifa.new_y = new_y;
  assign ifb.step  = step_b;
  assign ifb.grow  = grow;
  assign ifb.new_x = new_x;
  assign ifb.new_y = new_y;

  snake_body_queue #(.MAX_LEN(LA)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa.slave));
  snake_body_queue #(.MAX_LEN(LB)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb.slave));

  obs_t oa, ob, o;
  assign oa = '{busy: ifa.busy, done: ifa.done, collision: ifa.collision,
                set_valid: ifa.set_valid, clear_valid: ifa.clear_valid, full: ifa.full,
                set_x: ifa.set_x, set_y: ifa.set_y, clear_x: ifa.clear_x, clear_y: ifa.clear_y,
                head_x: ifa.head_x, head_y: ifa.head_y, tail_x: ifa.tail_x, tail_y: ifa.tail_y,
                length: 8'(ifa.length)};
  assign ob = '{busy: ifb.busy, done: ifb.done, collision: ifb.collision,
                set_valid: ifb.set_valid, clear_valid: ifb.clear_valid, full: ifb.full,
                set_x: ifb.set_x, set_y: ifb.set_y, clear_x: ifb.clear_x, clear_y: ifb.clear_y,
                head_x: ifb.head_x, head_y: ifb.head_y, tail_x: ifb.tail_x, tail_y: ifb.tail_y,
                length: 8'(ifb.length)};
  assign o = sel ? ob : oa;

  // Model: body as tail-first queues of coordinates, plus the sticky game-over flag.
  int mx[$];
  int my[$];
  bit mcol;
  int mmax;
  int total = 0;
  int bad   = 0;

  task automatic set_step(input logic v);
    if (sel) step_b = v;
    else     step_a = v;
  endtask

  task automatic reset_dut(input bit s);
    sel = s;
    step_a = 1'b0;
    step_b = 1'b0;
    @(negedge clk);
    if (s) rst_n_b = 1'b0;
    else   rst_n_a = 1'b0;
    @(negedge clk);
    if (s) rst_n_b = 1'b1;
    else   rst_n_a = 1'b1;
    mx = {9};
    my = {9};
    mcol = 1'b0;
    mmax = s ? LB : LA;
    #1;
  endtask

  task automatic check_state(input string tag);
    total++;
    if (o.length !== 8'(mx.size())) begin
      bad++; $display("FAIL %s length: got %0d expected %0d", tag, o.length, mx.size());
    end
    total++;
    if (o.head_x !== 5'(mx[$]) || o.head_y !== 5'(my[$])) begin
      bad++; $display("FAIL %s head: got (%0d,%0d) expected (%0d,%0d)", tag, o.head_x, o.head_y, mx[$], my[$]);
    end
    total++;
    if (o.tail_x !== 5'(mx[0]) || o.tail_y !== 5'(my[0])) begin
      bad++; $display("FAIL %s tail: got (%0d,%0d) expected (%0d,%0d)", tag, o.tail_x, o.tail_y, mx[0], my[0]);
    end
    total++;
    if (o.full !== (mx.size() == mmax)) begin
      bad++; $display("FAIL %s full: got %0b expected %0b", tag, o.full, mx.size() == mmax);
    end
    total++;
    if (o.collision !== mcol) begin
      bad++; $display("FAIL %s collision: got %0b expected %0b", tag, o.collision, mcol);
    end
  endtask

  // One step request; poke re-raises step with scrambled inputs while the queue is busy.
  task automatic do_step(input logic [4:0] x, input logic [4:0] y, input bit g_in, input bit poke);
    int  len, exp_done, cx, cy, limit;
    bit  ign, g, exp_col, exp_clear, seen;
    len = mx.size();
    ign = mcol;
    g = g_in && (len < mmax);
    exp_col = 1'b0;
    exp_done = len + 2;
    if (x >= 18 || y >= 18) begin
      exp_col = 1'b1;
      exp_done = 2;
    end else begin
      for (int i = 0; i < len; i++)
        if (!exp_col && (i > 0 || g) && mx[i] == int'(x) && my[i] == int'(y)) begin
          exp_col = 1'b1;
          exp_done = i + 3;
        end
    end
    exp_clear = !exp_col && !g;
    cx = mx[0];
    cy = my[0];
    limit = ign ? 6 : mmax + 8;

    @(negedge clk);
    set_step(1'b1);
    new_x = x;
    new_y = y;
    grow  = g_in;
    @(negedge clk);
    if (poke && !ign) begin
      new_x = 5'($urandom);
      new_y = 5'($urandom);
      grow  = ~g_in;
    end else set_step(1'b0);

    seen = 1'b0;
    for (int c = 1; c <= limit && !seen; c++) begin
      if (c == 2) set_step(1'b0);
      if (ign) begin
        total++;
        if (o.done !== 1'b0 || o.busy !== 1'b0) begin
          bad++; $display("FAIL ignored_step cycle %0d: got done=%0b busy=%0b expected 0 0", c, o.done, o.busy);
        end
      end else if (o.done === 1'b1) begin
        seen = 1'b1;
        total++;
        if (c != exp_done) begin
          bad++; $display("FAIL done_latency: got cycle %0d expected cycle %0d", c, exp_done);
        end
        total++;
        if (o.set_valid !== !exp_col || o.clear_valid !== exp_clear || o.busy !== 1'b0) begin
          bad++; $display("FAIL done_pulses: got set=%0b clear=%0b busy=%0b expected %0b %0b 0",
                          o.set_valid, o.clear_valid, o.busy, !exp_col, exp_clear);
        end
        if (!exp_col) begin
          total++;
          if (o.set_x !== x || o.set_y !== y) begin
            bad++; $display("FAIL set_coord: got (%0d,%0d) expected (%0d,%0d)", o.set_x, o.set_y, x, y);
          end
        end
        if (exp_clear) begin
          total++;
          if (o.clear_x !== 5'(cx) || o.clear_y !== 5'(cy)) begin
            bad++; $display("FAIL clear_coord: got (%0d,%0d) expected (%0d,%0d)", o.clear_x, o.clear_y, cx, cy);
          end
        end
      end else begin
        total++;
        if (o.busy !== 1'b1 || o.set_valid !== 1'b0 || o.clear_valid !== 1'b0) begin
          bad++; $display("FAIL busy_phase cycle %0d: got busy=%0b set=%0b clear=%0b expected 1 0 0",
                          c, o.busy, o.set_valid, o.clear_valid);
        end
      end
      if (!seen && c < limit) @(negedge clk);
    end
    set_step(1'b0);
    if (!ign && !seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done in %0d cycles expected cycle %0d", limit, exp_done);
    end

    if (!ign) begin
      if (exp_col) mcol = 1'b1;
      else begin
        if (!g) begin
          void'(mx.pop_front());
          void'(my.pop_front());
        end
        mx.push_back(int'(x));
        my.push_back(int'(y));
      end
    end
    check_state(ign ? "after_ignored" : "after_step");
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    step_a = 1'b0;
    step_b = 1'b0;
    grow = 1'b0;
    new_x = '0;
    new_y = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (o.busy !== 1'b0 || o.done !== 1'b0 || o.set_valid !== 1'b0 || o.clear_valid !== 1'b0
          || o.set_x !== 5'd0 || o.clear_y !== 5'd0) begin
        bad++; $display("FAIL reset_outputs dut%0d: got busy=%0b done=%0b set=%0b clear=%0b", s, o.busy, o.done, o.set_valid, o.clear_valid);
      end
      mx = {9}; my = {9}; mcol = 1'b0; mmax = s ? LB : LA;
      check_state("reset");
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
  endtask

  task automatic test_single_move();
    reset_dut(1'b0);
    do_step(5'd10, 5'd9, 1'b0, 1'b0);
  endtask

  task automatic test_grow();
    reset_dut(1'b0);
    for (int i = 1; i <= 3; i++) do_step(5'(9 + i), 5'd9, 1'b1, i == 2);
  endtask

  task automatic test_body_hit();
    reset_dut(1'b0);
    do_step(5'd10, 5'd9, 1'b1, 1'b0);
    do_step(5'd10, 5'd10, 1'b1, 1'b0);
    do_step(5'd9, 5'd10, 1'b1, 1'b0);
    do_step(5'd8, 5'd10, 1'b1, 1'b0);
    do_step(5'd9, 5'd10, 1'b0, 1'b0);
    do_step(5'd8, 5'd11, 1'b0, 1'b0);
  endtask

  task automatic test_tail_chase();
    for (int gi = 0; gi < 2; gi++) begin
      reset_dut(1'b0);
      do_step(5'd10, 5'd9, 1'b1, 1'b0);
      do_step(5'd10, 5'd10, 1'b1, 1'b0);
      do_step(5'd9, 5'd10, 1'b1, 1'b0);
      do_step(5'd9, 5'd9, gi[0], 1'b0);
    end
  endtask

  task automatic test_walls();
    reset_dut(1'b0);
    for (int i = 8; i >= 0; i--) do_step(5'(i), 5'd9, 1'b0, 1'b0);
    do_step(5'd31, 5'd9, 1'b0, 1'b1);
    reset_dut(1'b0);
    for (int i = 10; i <= 17; i++) do_step(5'(i), 5'd9, 1'b0, 1'b0);
    for (int j = 8; j >= 5; j--) do_step(5'd17, 5'(j), 1'b0, 1'b0);
    do_step(5'd18, 5'd5, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_and_abort();
    int path_x[10] = '{14, 13, 12, 11, 10, 10, 11, 12, 13, 14};
    int path_y[10] = '{10, 10, 10, 10, 10, 11, 11, 11, 11, 11};
    reset_dut(1'b1);
    for (int i = 1; i <= 5; i++) do_step(5'(9 + i), 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) do_step(5'(path_x[i]), 5'(path_y[i]), 1'b0, 1'b0);
    @(negedge clk);
    set_step(1'b1);
    new_x = 5'd15;
    new_y = 5'd11;
    grow  = 1'b0;
    @(negedge clk);
    set_step(1'b0);
    @(negedge clk);
    #2 rst_n_b = 1'b0;
    #1;
    total++;
    if (o.busy !== 1'b0 || o.done !== 1'b0 || o.set_valid !== 1'b0 || o.clear_valid !== 1'b0) begin
      bad++; $display("FAIL abort_reset: got busy=%0b done=%0b set=%0b clear=%0b expected 0 0 0 0", o.busy, o.done, o.set_valid, o.clear_valid);
    end
    mx = {9}; my = {9}; mcol = 1'b0;
    check_state("abort_reset");
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (o.done !== 1'b0 || o.set_valid !== 1'b0 || o.clear_valid !== 1'b0 || o.busy !== 1'b0) begin
        bad++; $display("FAIL abort_quiet cycle %0d: got done=%0b set=%0b clear=%0b busy=%0b", c, o.done, o.set_valid, o.clear_valid, o.busy);
      end
    end
    check_state("abort_after");
  endtask

  task automatic test_random(input bit s, input int n);
    logic [4:0] x, y;
    bit g;
    reset_dut(s);
    for (int k = 0; k < n; k++) begin
      x = 5'(mx[$]);
      y = 5'(my[$]);
      case ($urandom_range(0, 3))
        0: x = x + 5'd1;
        1: x = x - 5'd1;
        2: y = y + 5'd1;
        default: y = y - 5'd1;
      endcase
      if ($urandom_range(0, 15) == 0) x = 5'($urandom_range(18, 31));
      g = ($urandom_range(0, 2) == 0);
      do_step(x, y, g, $urandom_range(0, 3) == 0);
      if (mcol) begin
        if ($urandom_range(0, 1) == 0) do_step(x, y, g, 1'b0);
        reset_dut(s);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_move();
    test_grow();
    test_body_hit();
    test_tail_chase();
    test_walls();
    test_wrap_and_abort();
    test_random(1'b0, 150);
    test_random(1'b1, 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
